// File: rtl/alu_uart_sequencer_pkg.sv
// Shared definitions for the ALU/UART frame sequencer: opcode codes,
// default opcode width and the sequencer state encoding.
package alu_uart_sequencer_pkg;

  localparam int NB_OP_DEFAULT = 6;
  localparam int OPCODE_W      = 6;

  localparam logic [OPCODE_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OPCODE_W-1:0] OP_SUB = 6'b100010;
  localparam logic [OPCODE_W-1:0] OP_AND = 6'b100100;
  localparam logic [OPCODE_W-1:0] OP_OR  = 6'b100101;
  localparam logic [OPCODE_W-1:0] OP_XOR = 6'b100110;
  localparam logic [OPCODE_W-1:0] OP_NOR = 6'b100111;
  localparam logic [OPCODE_W-1:0] OP_SRA = 6'b000011;
  localparam logic [OPCODE_W-1:0] OP_SRL = 6'b000010;

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_CHECK   = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } seq_state_e;

  function automatic logic opcode_is_valid(input logic [OPCODE_W-1:0] op);
    logic valid;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL: valid = 1'b1;
      default:                        valid = 1'b0;
    endcase
    return valid;
  endfunction

endpackage

// File: rtl/alu_uart_sequencer_checker.sv
// Protocol properties of the sequencer outputs, kept apart from the datapath.
module alu_uart_sequencer_checker (
  input logic clock,
  input logic reset_n,
  input logic tx_start,
  input logic error,
  input logic busy
);

  a_start_single_cycle: assert property (@(posedge clock) disable iff (!reset_n)
    tx_start |=> !tx_start);

  a_error_single_cycle: assert property (@(posedge clock) disable iff (!reset_n)
    error |=> !error);

  a_start_excludes_error: assert property (@(posedge clock) disable iff (!reset_n)
    !(tx_start && error));

  a_start_while_busy: assert property (@(posedge clock) disable iff (!reset_n)
    tx_start |-> busy);

endmodule

// File: rtl/alu_uart_sequencer_frame_timeout_counter.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count sits at its final value.
module alu_uart_sequencer_frame_timeout_counter #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count_r;

  // Idle-cycle counter; saturates at LAST so it can never wrap.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      count_r <= {CNT_W{1'b0}};
    end else if (enable && (count_r != LAST)) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  // Must not depend on clear: the sequencer derives clear from its next state.
  assign expired = enable && (count_r == LAST);

endmodule

// File: rtl/alu_uart_sequencer.sv
// Collects operand A, operand B and opcode bytes from a UART receiver, drives
// them to an external ALU and forwards the result byte to the UART transmitter.
module alu_uart_sequencer
  import alu_uart_sequencer_pkg::*;
#(
  parameter int DBIT        = 8,
  parameter int NB_OP       = NB_OP_DEFAULT,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [DBIT-1:0]  i_rx_data,
  input  logic             i_rx_done,
  input  logic             i_tx_done,
  input  logic [DBIT-1:0]  i_alu_result,
  output logic [DBIT-1:0]  o_data_a,
  output logic [DBIT-1:0]  o_data_b,
  output logic [NB_OP-1:0] o_opcode,
  output logic [DBIT-1:0]  o_tx_data,
  output logic             o_tx_start,
  output logic             o_busy,
  output logic             o_error
);

  localparam int OPW = (NB_OP > OPCODE_W) ? NB_OP : OPCODE_W;

  seq_state_e       state_r;
  seq_state_e       state_next_s;
  logic [DBIT-1:0]  data_a_r;
  logic [DBIT-1:0]  data_b_r;
  logic [NB_OP-1:0] opcode_r;
  logic [DBIT-1:0]  tx_data_r;
  logic             tx_start_r;
  logic             busy_r;
  logic             error_r;

  logic             load_a_s;
  logic             load_b_s;
  logic             load_op_s;
  logic             latch_tx_s;
  logic             start_s;
  logic             error_s;
  logic             accept_s;
  logic             clear_s;
  logic             enable_s;
  logic             expired_s;
  logic             op_valid_s;
  logic [OPW-1:0]   op_wide_s;

  // A wider opcode field is only valid when its extra high bits are zero.
  assign op_wide_s  = OPW'(opcode_r);
  assign op_valid_s = ((op_wide_s >> OPCODE_W) == {OPW{1'b0}})
                      && opcode_is_valid(op_wide_s[OPCODE_W-1:0]);

  assign enable_s = (state_r == ST_WAIT_B) || (state_r == ST_WAIT_OP);
  assign clear_s  = accept_s || (state_next_s != state_r);

  alu_uart_sequencer_frame_timeout_counter #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_frame_timeout_counter (
    .clock   (i_clock),
    .reset_n (i_reset),
    .clear   (clear_s),
    .enable  (enable_s),
    .expired (expired_s)
  );

  // Next-state and datapath strobes; a received byte outranks a timeout.
  always_comb begin
    state_next_s = state_r;
    load_a_s     = 1'b0;
    load_b_s     = 1'b0;
    load_op_s    = 1'b0;
    latch_tx_s   = 1'b0;
    start_s      = 1'b0;
    error_s      = 1'b0;
    accept_s     = 1'b0;
    case (state_r)
      ST_WAIT_A: begin
        if (i_rx_done) begin
          load_a_s     = 1'b1;
          accept_s     = 1'b1;
          state_next_s = ST_WAIT_B;
        end else begin
          state_next_s = ST_WAIT_A;
        end
      end
      ST_WAIT_B: begin
        if (i_rx_done) begin
          load_b_s     = 1'b1;
          accept_s     = 1'b1;
          state_next_s = ST_WAIT_OP;
        end else if (expired_s) begin
          error_s      = 1'b1;
          state_next_s = ST_WAIT_A;
        end else begin
          state_next_s = ST_WAIT_B;
        end
      end
      ST_WAIT_OP: begin
        if (i_rx_done) begin
          load_op_s    = 1'b1;
          accept_s     = 1'b1;
          state_next_s = ST_CHECK;
        end else if (expired_s) begin
          error_s      = 1'b1;
          state_next_s = ST_WAIT_A;
        end else begin
          state_next_s = ST_WAIT_OP;
        end
      end
      ST_CHECK: begin
        if (op_valid_s) begin
          latch_tx_s   = 1'b1;
          start_s      = 1'b1;
          state_next_s = ST_SEND;
        end else begin
          error_s      = 1'b1;
          state_next_s = ST_WAIT_A;
        end
      end
      ST_SEND: begin
        state_next_s = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (i_tx_done) begin
          state_next_s = ST_WAIT_A;
        end else begin
          state_next_s = ST_WAIT_TX;
        end
      end
      default: begin
        state_next_s = ST_WAIT_A;
      end
    endcase
  end

  // State, operand and output registers; reset outranks every other event.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_r    <= ST_WAIT_A;
      data_a_r   <= {DBIT{1'b0}};
      data_b_r   <= {DBIT{1'b0}};
      opcode_r   <= {NB_OP{1'b0}};
      tx_data_r  <= {DBIT{1'b0}};
      tx_start_r <= 1'b0;
      busy_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      tx_start_r <= start_s;
      error_r    <= error_s;
      busy_r     <= (state_next_s != ST_WAIT_A);
      if (load_a_s) begin
        data_a_r <= i_rx_data;
      end
      if (load_b_s) begin
        data_b_r <= i_rx_data;
      end
      if (load_op_s) begin
        opcode_r <= i_rx_data[NB_OP-1:0];
      end
      if (latch_tx_s) begin
        tx_data_r <= i_alu_result;
      end
    end
  end

  assign o_data_a   = data_a_r;
  assign o_data_b   = data_b_r;
  assign o_opcode   = opcode_r;
  assign o_tx_data  = tx_data_r;
  assign o_tx_start = tx_start_r;
  assign o_busy     = busy_r;
  assign o_error    = error_r;

  alu_uart_sequencer_checker u_checker (
    .clock    (i_clock),
    .reset_n  (i_reset),
    .tx_start (tx_start_r),
    .error    (error_r),
    .busy     (busy_r)
  );

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Directed bench for alu_uart_sequencer: an event-timeline model predicts every
// output per cycle, and literal checks pin the key results.
module tb_alu_uart_sequencer;

  localparam int MAXC = 2048;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_done;
  logic [7:0] alu_res;
  logic [7:0] data_a, data_b, tx_data;
  logic [5:0] opcode;
  logic       tx_start, busy, error;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    logic [7:0] r;
    case (op)
      6'h20:   r = a + b;
      6'h22:   r = a - b;
      6'h24:   r = a & b;
      6'h25:   r = a | b;
      6'h26:   r = a ^ b;
      6'h27:   r = ~(a | b);
      6'h03:   r = 8'($signed(a) >>> b);
      6'h02:   r = a >> b;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic bit op_valid(input logic [5:0] op);
    return op inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
  endfunction

  assign alu_res = alu_ref(data_a, data_b, opcode);

  alu_uart_sequencer #(.DBIT(8), .NB_OP(6), .TIMEOUT_CYC(16)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_tx_done(tx_done), .i_alu_result(alu_res), .o_data_a(data_a), .o_data_b(data_b),
    .o_opcode(opcode), .o_tx_data(tx_data), .o_tx_start(tx_start), .o_busy(busy),
    .o_error(error)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  // Expected event timeline, indexed by cycle number.
  bit         exp_start [MAXC];
  logic [7:0] exp_txd   [MAXC];
  bit         exp_err   [MAXC];
  bit         exp_busy  [MAXC];
  bit         rst_mark  [MAXC];
  bit         upd_a_v   [MAXC];
  bit         upd_b_v   [MAXC];
  bit         upd_op_v  [MAXC];
  logic [7:0] upd_a     [MAXC];
  logic [7:0] upd_b     [MAXC];
  logic [5:0] upd_op    [MAXC];

  logic [7:0] cur_a = 8'h00, cur_b = 8'h00, cur_txd = 8'h00;
  logic [5:0] cur_op = 6'h00;

  int         obs_start_cyc[$];
  logic [7:0] obs_start_data[$];
  int         obs_err_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the timeline model.
  always @(negedge clk) begin
    if (chk_en && cyc < MAXC) begin
      if (rst_mark[cyc]) begin
        cur_a = 8'h00; cur_b = 8'h00; cur_op = 6'h00; cur_txd = 8'h00;
      end
      if (upd_a_v[cyc])   cur_a   = upd_a[cyc];
      if (upd_b_v[cyc])   cur_b   = upd_b[cyc];
      if (upd_op_v[cyc])  cur_op  = upd_op[cyc];
      if (exp_start[cyc]) cur_txd = exp_txd[cyc];
      chk("tx_start", tx_start, exp_start[cyc]);
      chk("error",    error,    exp_err[cyc]);
      chk("busy",     busy,     exp_busy[cyc]);
      chk("data_a",   data_a,   cur_a);
      chk("data_b",   data_b,   cur_b);
      chk("opcode",   opcode,   cur_op);
      chk("tx_data",  tx_data,  cur_txd);
      if (tx_start === 1'b1) begin
        obs_start_cyc.push_back(cyc);
        obs_start_data.push_back(tx_data);
      end
      if (error === 1'b1) obs_err_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic mark_busy(input int from, input int to);
    for (int i = from; i <= to; i++) exp_busy[i] = 1'b1;
  endtask

  // slot: 0 = operand A, 1 = operand B, 2 = opcode, other = byte must be dropped
  task automatic send_byte(input logic [7:0] v, input int slot);
    if (slot == 0) begin
      upd_a_v[cyc+1] = 1'b1; upd_a[cyc+1] = v;
    end else if (slot == 1) begin
      upd_b_v[cyc+1] = 1'b1; upd_b[cyc+1] = v;
    end else if (slot == 2) begin
      upd_op_v[cyc+1] = 1'b1; upd_op[cyc+1] = v[5:0];
    end
    rx_data = v;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic pulse_tx();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  // Plays a whole frame; the timeline is predicted up front from the frame rules.
  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input int gap_ab, input int gap_bo, input int txwait,
                           input bit poke, output int c_op);
    int c0, d;
    c0   = cyc;
    c_op = c0 + 2 + gap_ab + gap_bo;
    if (op_valid(op[5:0])) begin
      d = c_op + (poke ? 4 : 3) + txwait;
      exp_start[c_op+2] = 1'b1;
      exp_txd[c_op+2]   = alu_ref(a, b, op[5:0]);
      mark_busy(c0 + 1, d);
    end else begin
      exp_err[c_op+2] = 1'b1;
      mark_busy(c0 + 1, c_op + 1);
    end
    send_byte(a, 0);
    idle(gap_ab);
    send_byte(b, 1);
    idle(gap_bo);
    send_byte(op, 2);
    if (op_valid(op[5:0])) begin
      if (poke) begin
        send_byte(8'h77, -1);
        tx_done = 1'b1;
        send_byte(8'h77, -1);
        tx_done = 1'b0;
        send_byte(8'h77, -1);
      end else begin
        idle(2);
      end
      idle(txwait);
      pulse_tx();
    end else begin
      idle(2);
    end
  endtask

  initial begin
    int c0, c_op, ns, ne;
    rst_n = 1'b0; rx_data = 8'h00; rx_done = 1'b0; tx_done = 1'b0;
    rst_mark[1] = 1'b1;
    rst_mark[2] = 1'b1;
    tick();
    tick();
    chk_en = 1'b1;
    rst_n  = 1'b1;
    @(negedge clk);
    chk("reset busy", busy, 1'b0);
    chk("reset tx_start", tx_start, 1'b0);
    chk("reset data_a", data_a, 8'h00);
    tick();
    pulse_tx();

    // ADD frame, latency and busy release
    ns = obs_start_cyc.size();
    run_frame(8'h05, 8'h03, 8'h20, 0, 0, 3, 1'b0, c_op);
    chk("add start count", obs_start_cyc.size() - ns, 1);
    chk("add latency", obs_start_cyc[$] - c_op, 2);
    chk("add data", obs_start_data[$], 8'h08);
    @(negedge clk);
    chk("add busy after tx_done", busy, 1'b0);
    tick();

    // Invalid opcodes
    ns = obs_start_cyc.size(); ne = obs_err_cyc.size();
    run_frame(8'h0F, 8'h01, 8'h3F, 1, 0, 0, 1'b0, c_op);
    chk("invalid err count", obs_err_cyc.size() - ne, 1);
    chk("invalid err cycle", obs_err_cyc[$] - c_op, 2);
    run_frame(8'h0F, 8'h01, 8'h01, 0, 0, 0, 1'b0, c_op);
    chk("invalid start count", obs_start_cyc.size() - ns, 0);
    @(negedge clk);
    chk("invalid idle busy", busy, 1'b0);
    tick();

    // Timeout in WAIT_B, then a SUB frame
    ne = obs_err_cyc.size();
    c0 = cyc;
    exp_err[c0+17] = 1'b1;
    mark_busy(c0 + 1, c0 + 16);
    send_byte(8'h11, 0);
    idle(3);
    pulse_tx();
    idle(c0 + 19 - cyc);
    chk("timeout B err count", obs_err_cyc.size() - ne, 1);
    chk("timeout B err cycle", obs_err_cyc[$] - c0, 17);
    run_frame(8'h02, 8'h02, 8'h22, 0, 0, 1, 1'b0, c_op);
    chk("sub data", obs_start_data[$], 8'h00);

    // Timeout in WAIT_OP keeps the operands
    c0 = cyc;
    exp_err[c0+18] = 1'b1;
    mark_busy(c0 + 1, c0 + 17);
    send_byte(8'h33, 0);
    send_byte(8'h44, 1);
    idle(c0 + 20 - cyc);
    chk("timeout OP err cycle", obs_err_cyc[$] - c0, 18);
    @(negedge clk);
    chk("timeout keeps A", data_a, 8'h33);
    chk("timeout keeps B", data_b, 8'h44);
    tick();

    // Bytes coincident with expiry are accepted
    ne = obs_err_cyc.size();
    run_frame(8'h07, 8'h03, 8'h26, 15, 15, 2, 1'b0, c_op);
    chk("expiry xor data", obs_start_data[$], 8'h04);
    chk("expiry no error", obs_err_cyc.size() - ne, 0);

    // Bytes during CHECK/SEND/WAIT_TX dropped, then a fresh frame
    run_frame(8'h0C, 8'h0A, 8'h24, 1, 2, 4, 1'b1, c_op);
    chk("and data", obs_start_data[$], 8'h08);
    run_frame(8'h01, 8'h02, 8'h25, 0, 0, 0, 1'b0, c_op);
    chk("or data", obs_start_data[$], 8'h03);

    // Opcode masking, SRA and NOR
    run_frame(8'h80, 8'h01, 8'hC3, 0, 0, 0, 1'b0, c_op);
    chk("sra data", obs_start_data[$], 8'hC0);
    run_frame(8'h0F, 8'h30, 8'h27, 0, 1, 0, 1'b0, c_op);
    chk("nor data", obs_start_data[$], 8'hC0);
    run_frame(8'hF0, 8'h20, 8'hE0, 0, 0, 0, 1'b0, c_op);
    chk("masked add data", obs_start_data[$], 8'h10);

    // Reset after the second byte, coincident byte ignored
    ns = obs_start_cyc.size();
    c0 = cyc;
    mark_busy(c0 + 1, c0 + 2);
    rst_mark[c0+3] = 1'b1;
    send_byte(8'h44, 0);
    send_byte(8'h55, 1);
    rst_n   = 1'b0;
    rx_data = 8'h66;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    chk("mid reset data_a", data_a, 8'h00);
    chk("mid reset data_b", data_b, 8'h00);
    chk("mid reset tx_data", tx_data, 8'h00);
    chk("mid reset busy", busy, 1'b0);
    tick();
    idle(2);
    run_frame(8'h80, 8'h01, 8'h02, 0, 0, 1, 1'b0, c_op);
    idle(5);
    chk("post reset start count", obs_start_cyc.size() - ns, 1);
    chk("srl data", obs_start_data[$], 8'h40);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_uart_sequencer.md
ALU_UART_SEQUENCER -- requirements
Module: alu_uart_sequencer

Interface
REQ-001 Parameter DBIT, default 8, data/operand width in bits.
REQ-002 Parameter NB_OP, default 6, opcode width (low NB_OP bits of the opcode byte).
REQ-003 Parameter TIMEOUT_CYC, default 1000000, max clock cycles allowed between bytes of one frame.
REQ-004 i_clock  in  1  single system clock; all logic on rising edge.
REQ-005 i_reset  in  1  synchronous, active-low reset.
REQ-006 i_rx_data  in  DBIT  byte from UART receiver.
REQ-007 i_rx_done  in  1  one-cycle pulse: i_rx_data valid.
REQ-008 i_tx_done  in  1  one-cycle pulse: transmitter finished current byte.
REQ-009 i_alu_result  in  DBIT  combinational ALU result for o_data_a/o_data_b/o_opcode.
REQ-010 o_data_a  out  DBIT  registered operand A to ALU.
REQ-011 o_data_b  out  DBIT  registered operand B to ALU.
REQ-012 o_opcode  out  NB_OP  registered opcode to ALU.
REQ-013 o_tx_data  out  DBIT  byte to transmitter, held stable from o_tx_start until i_tx_done.
REQ-014 o_tx_start  out  1  one-cycle pulse starting a transmission.
REQ-015 o_busy  out  1  high in every state except WAIT_A.
REQ-016 o_error  out  1  one-cycle pulse on invalid opcode or timeout.

Function
REQ-017 FSM states: WAIT_A, WAIT_B, WAIT_OP, CHECK, SEND, WAIT_TX.
REQ-018 WAIT_A: on i_rx_done, o_data_a <= i_rx_data, go WAIT_B.
REQ-019 WAIT_B: on i_rx_done, o_data_b <= i_rx_data, go WAIT_OP.
REQ-020 WAIT_OP: on i_rx_done, o_opcode <= i_rx_data[NB_OP-1:0], go CHECK.
REQ-021 CHECK (1 cycle): opcode valid -> latch i_alu_result into o_tx_data, go SEND; invalid -> pulse o_error, go WAIT_A, no transmission.
REQ-022 Valid opcodes: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011, SRL 000010; all others invalid.
REQ-023 SEND: assert o_tx_start exactly one cycle, go WAIT_TX; latency opcode-byte i_rx_done to o_tx_start = 2 cycles.
REQ-024 WAIT_TX: on i_tx_done go WAIT_A; i_rx_done in WAIT_TX, SEND or CHECK is ignored (byte dropped).
REQ-025 Timeout counter clears on every state change and on each accepted i_rx_done; counts only in WAIT_B/WAIT_OP.
REQ-026 Counter reaching TIMEOUT_CYC-1 -> o_error pulse, go WAIT_A, operand registers unchanged; i_rx_done in that same cycle has priority (byte accepted, no error).
REQ-027 Counter width = clog2(TIMEOUT_CYC); no wrap-around possible.
REQ-028 i_tx_done outside WAIT_TX ignored.
REQ-029 o_data_a/o_data_b/o_opcode retain values until overwritten by the next accepted byte.

Reset
REQ-030 On i_reset low at a rising edge: state WAIT_A, counter 0, o_data_a/o_data_b/o_tx_data 0, o_opcode 0, o_tx_start 0, o_error 0, o_busy 0.
REQ-031 Reset mid-frame or mid-transmission discards the partial frame; no o_tx_start after reset release until a full new frame is received.
REQ-032 Reset has priority over every other event in the same cycle.

Structure
REQ-033 Shared package holds opcode constants (8 codes above), NB_OP default and the FSM state encoding.
REQ-034 One sub-module natural: frame_timeout_counter (clear, enable, expired pulse), parameterised by TIMEOUT_CYC.
REQ-035 Block instantiated beside the existing UART transmitter, receiver and baud-rate generator; it does not generate ticks.

Verification
REQ-036 Bytes 0x05, 0x03, 0x20 (ADD), ALU model returns 0x08 -> o_tx_start 2 cycles after third i_rx_done, o_tx_data 0x08, o_busy low after i_tx_done.
REQ-037 Bytes 0x0F, 0x01, 0x3F (invalid) -> o_error one pulse, no o_tx_start, state WAIT_A.
REQ-038 TIMEOUT_CYC=16: byte 0x11 then silence -> o_error 16 cycles after state enters WAIT_B; next bytes 0x02, 0x02, 0x22 (SUB) -> o_tx_data 0x00.
REQ-039 i_rx_done pulse during WAIT_TX -> byte ignored, next frame starts fresh after i_tx_done.
REQ-040 i_reset low for one cycle after second byte -> all outputs 0; following full frame 0x80, 0x01, 0x02 (SRL) produces exactly one o_tx_start.
REQ-041 i_rx_done coincident with timeout expiry in WAIT_OP -> byte accepted as opcode, no o_error.
